// File: rtl/nco_sweep_ctrl_if.sv
// nco_sweep_ctrl_if: request/config inputs and NCO-facing outputs of the sweep sequencer
interface nco_sweep_ctrl_if #(parameter int DWELL_W = 16);
    logic               start;
    logic               abort;
    logic [1:0]         mode;
    logic [31:0]        f_start;
    logic [31:0]        f_stop;
    logic [31:0]        f_step;
    logic [DWELL_W-1:0] dwell;
    logic [31:0]        ctrl;
    logic               nco_rst;
    logic               busy;
    logic               done;
    modport master (output start, abort, mode, f_start, f_stop, f_step, dwell,
                    input  ctrl, nco_rst, busy, done);
    modport slave  (input  start, abort, mode, f_start, f_stop, f_step, dwell,
                    output ctrl, nco_rst, busy, done);
endinterface

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps the NCO control word from f_start to f_stop with per-frequency dwell
module nco_sweep_ctrl #(parameter int DWELL_W = 16) (
    input logic              clk,
    input logic              rst,
    nco_sweep_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t             state, state_n;
    logic [31:0]        ctrl_q, ctrl_n, org, org_n, tgt, tgt_n, step, step_n;
    logic [DWELL_W-1:0] cnt, cnt_n, dw, dw_n;
    logic [1:0]         md, md_n;
    logic               dir, dir_n, busy_q, busy_n, nco_q, nco_n, done_q, done_n;

    // one step toward lim; 33-bit so a carry/borrow out also clamps to lim
    function automatic logic [31:0] advance(input logic [31:0] cur, lim, stp, input logic up);
        logic [32:0] sum;
        sum = up ? {1'b0, cur} + {1'b0, stp} : {1'b0, cur} - {1'b0, stp};
        return (sum[32] || (up ? sum[31:0] > lim : sum[31:0] < lim)) ? lim : sum[31:0];
    endfunction

    // next-state and next-register values; abort overrides everything
    always_comb begin
        state_n = state;
        ctrl_n  = ctrl_q;
        org_n   = org;
        tgt_n   = tgt;
        step_n  = step;
        cnt_n   = cnt;
        dw_n    = dw;
        md_n    = md;
        dir_n   = dir;
        busy_n  = busy_q;
        nco_n   = 1'b0;
        done_n  = 1'b0;
        if (bus.abort) begin
            state_n = IDLE;
            ctrl_n  = '0;
            busy_n  = 1'b0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    md_n    = bus.mode;
                    org_n   = bus.f_start;
                    tgt_n   = bus.f_stop;
                    step_n  = (bus.f_step == '0) ? 32'd1 : bus.f_step;
                    dw_n    = bus.dwell;
                    dir_n   = bus.f_stop >= bus.f_start;
                    busy_n  = 1'b1;
                    state_n = LOAD;
                end
                LOAD: begin
                    ctrl_n  = org;
                    nco_n   = 1'b1;
                    cnt_n   = dw;
                    state_n = RUN;
                end
                RUN: if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    cnt_n = dw;
                    if (ctrl_q != tgt) begin
                        ctrl_n = advance(ctrl_q, tgt, step, dir);
                    end else if (md == 2'd1) begin
                        ctrl_n = org;
                    end else if (md == 2'd2) begin
                        org_n  = tgt;
                        tgt_n  = org;
                        dir_n  = ~dir;
                        ctrl_n = advance(ctrl_q, org, step, ~dir);
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // register bank with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ctrl_q <= '0;
            org    <= '0;
            tgt    <= '0;
            step   <= '0;
            cnt    <= '0;
            dw     <= '0;
            md     <= '0;
            dir    <= 1'b0;
            busy_q <= 1'b0;
            nco_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            ctrl_q <= ctrl_n;
            org    <= org_n;
            tgt    <= tgt_n;
            step   <= step_n;
            cnt    <= cnt_n;
            dw     <= dw_n;
            md     <= md_n;
            dir    <= dir_n;
            busy_q <= busy_n;
            nco_q  <= nco_n;
            done_q <= done_n;
        end
    end

    assign bus.ctrl    = ctrl_q;
    assign bus.nco_rst = nco_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
